// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port arbiter for the single-port DataMemory. Port 0 is the
//            CPU datapath and has fixed priority. Port 1 is the aux requester
//            (debug loader / display scanner). A starvation counter forces an
//            aux win after STARVE_LIMIT consecutive losses. Each transaction
//            runs IDLE -> ISSUE -> (WAIT_RD for reads) -> IDLE, and read data
//            is returned with a one-cycle valid pulse.
// Options  : DMEM_ARB_STATS_EN - when defined, builds 16-bit saturating
//            grant/conflict counters. Otherwise cnt_* are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [15:0]       cnt_cpu,
    output logic [15:0]       cnt_aux,
    output logic [15:0]       cnt_conflict
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ISSUE   = 2'd1;
    localparam logic [1:0] c_ST_WAIT_RD = 2'd2;

    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [3:0] c_STARVE_MAX   = 4'd15;

    logic [1:0]        r_state;
    logic              r_port;
    logic [3:0]        r_starve;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data_in;

    logic              w_any_req;
    logic              w_pick1;
    logic              w_sel_we;

    // Winner selection: aux wins when alone, or when it has starved long enough.
    always_comb begin
        w_any_req = req0 | req1;
        w_pick1   = req1 & (~req0 | (r_starve >= c_STARVE_LIMIT));
        w_sel_we  = w_pick1 ? we1 : we0;
    end

    // Transaction sequencer with registered strobes, grants and read returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_port        <= 1'b0;
            r_starve      <= 4'd0;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_rvalid0     <= 1'b0;
            r_rvalid1     <= 1'b0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
        end else begin
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any_req) begin
                        r_port        <= w_pick1;
                        r_mem_addr    <= w_pick1 ? addr1 : addr0;
                        r_mem_data_in <= w_pick1 ? wdata1 : wdata0;
                        r_gnt0        <= ~w_pick1;
                        r_gnt1        <= w_pick1;
                        r_mem_read    <= ~w_sel_we;
                        r_mem_write   <= w_sel_we;
                        r_state       <= c_ST_ISSUE;
                    end
                    // Aux loses only when both request and the CPU is chosen.
                    if (!req1 || w_pick1) begin
                        r_starve <= 4'd0;
                    end else if (r_starve != c_STARVE_MAX) begin
                        r_starve <= r_starve + 4'd1;
                    end
                end
                c_ST_ISSUE: begin
                    // The strobe of this cycle tells whether a read follows.
                    r_state <= r_mem_write ? c_ST_IDLE : c_ST_WAIT_RD;
                end
                c_ST_WAIT_RD: begin
                    if (r_port) begin
                        r_rdata1  <= mem_data_out;
                        r_rvalid1 <= 1'b1;
                    end else begin
                        r_rdata0  <= mem_data_out;
                        r_rvalid0 <= 1'b1;
                    end
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_cnt_cpu;
    logic [15:0] r_cnt_aux;
    logic [15:0] r_cnt_conflict;

    // Saturating statistics: grants per port and IDLE cycles with contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_cpu      <= 16'd0;
            r_cnt_aux      <= 16'd0;
            r_cnt_conflict <= 16'd0;
        end else begin
            if (r_gnt0 && (r_cnt_cpu != 16'hFFFF)) begin
                r_cnt_cpu <= r_cnt_cpu + 16'd1;
            end
            if (r_gnt1 && (r_cnt_aux != 16'hFFFF)) begin
                r_cnt_aux <= r_cnt_aux + 16'd1;
            end
            if ((r_state == c_ST_IDLE) && req0 && req1 && (r_cnt_conflict != 16'hFFFF)) begin
                r_cnt_conflict <= r_cnt_conflict + 16'd1;
            end
        end
    end

    assign cnt_cpu      = r_cnt_cpu;
    assign cnt_aux      = r_cnt_aux;
    assign cnt_conflict = r_cnt_conflict;
`else
    assign cnt_cpu      = 16'd0;
    assign cnt_aux      = 16'd0;
    assign cnt_conflict = 16'd0;
`endif

    assign gnt0        = r_gnt0;
    assign gnt1        = r_gnt1;
    assign rvalid0     = r_rvalid0;
    assign rvalid1     = r_rvalid1;
    assign rdata0      = r_rdata0;
    assign rdata1      = r_rdata1;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_addr    = r_mem_addr;
    assign mem_data_in = r_mem_data_in;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter with a behavioural
//            DataMemory, a transaction table, directed corner sequences and
//            a randomized run against a transaction-level reference model.
// Options  : DMEM_ARB_STATS_EN selects the expected statistics values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int c_ADDR_W       = 6;
    localparam int c_DATA_W       = 8;
    localparam int c_STARVE_LIMIT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, we0, we1;
    logic [5:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       mem_read, mem_write;
    logic [5:0] mem_addr;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;
    logic [15:0] cnt_cpu, cnt_aux, cnt_conflict;

    // Behavioural DataMemory: synchronous write, registered read.
    logic [7:0] mem [64];
    logic       pre_en;
    logic [5:0] pre_addr;
    logic [7:0] pre_data;
    logic [7:0] shadow [64];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (mem_write) mem[mem_addr] <= mem_data_in;
        if (mem_read) mem_data_out <= mem[mem_addr];
    end

    dmem_arbiter #(
        .ADDR_W       (c_ADDR_W),
        .DATA_W       (c_DATA_W),
        .STARVE_LIMIT (c_STARVE_LIMIT)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .rvalid0      (rvalid0),
        .rvalid1      (rvalid1),
        .rdata0       (rdata0),
        .rdata1       (rdata1),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .cnt_cpu      (cnt_cpu),
        .cnt_aux      (cnt_aux),
        .cnt_conflict (cnt_conflict)
    );

    typedef struct {
        bit         port;
        bit         we;
        logic [5:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [5:0] a, input logic [7:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        shadow[a] = d;
        step();
        pre_en = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write}, 32'd0);
        chk({name, "_bus"}, {mem_addr, mem_data_in, rdata0, rdata1}, 32'd0);
    endtask

    // One isolated transaction on one port with the arbiter idle.
    task automatic do_txn(input bit port, input bit we, input logic [5:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_rdata);
        logic [7:0] other_rd;
        other_rd = port ? rdata0 : rdata1;
        if (port) begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end
        step();
        chk("txn_gnt", {gnt0, gnt1}, port ? 32'b01 : 32'b10);
        chk("txn_strobe", {mem_read, mem_write}, we ? 32'b01 : 32'b10);
        chk("txn_addr", mem_addr, addr);
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        if (we) begin
            shadow[addr] = wdata;
        end else begin
            chk("txn_wait_quiet", {gnt0, gnt1, rvalid0, rvalid1}, 32'd0);
            step();
            chk("txn_rvalid", {rvalid0, rvalid1}, port ? 32'b01 : 32'b10);
            chk("txn_rdata", port ? rdata1 : rdata0, exp_rdata);
            chk("txn_other_rdata", port ? rdata0 : rdata1, other_rd);
        end
    endtask

    initial begin
        int          order[8];
        int          ng;
        int          cyc;
        int          bad;
        int          edge_idx;
        int          free_edge;
        int          losses;
        int          rv_edge;
        bit          rv_port;
        logic [7:0]  rv_data;
        bit          active[2];
        bit          s_req0, s_req1, s_we0, s_we1, win, wwe;
        logic [5:0]  s_addr0, s_addr1, waddr;
        logic [7:0]  s_wd0, s_wd1;
        logic [3:0]  exp_flags;
        int          exp_order[8];

        vecs[0] = '{port: 1'b0, we: 1'b1, addr: 6'h05, wdata: 8'hA7, exp_rdata: 8'h00};
        vecs[1] = '{port: 1'b0, we: 1'b0, addr: 6'h05, wdata: 8'h00, exp_rdata: 8'hA7};
        vecs[2] = '{port: 1'b1, we: 1'b0, addr: 6'h3F, wdata: 8'h00, exp_rdata: 8'h5C};
        vecs[3] = '{port: 1'b1, we: 1'b1, addr: 6'h10, wdata: 8'h3C, exp_rdata: 8'h00};
        vecs[4] = '{port: 1'b0, we: 1'b0, addr: 6'h10, wdata: 8'h00, exp_rdata: 8'h3C};
        vecs[5] = '{port: 1'b1, we: 1'b0, addr: 6'h05, wdata: 8'h00, exp_rdata: 8'hA7};
        vecs[6] = '{port: 1'b0, we: 1'b1, addr: 6'h3F, wdata: 8'h99, exp_rdata: 8'h00};
        vecs[7] = '{port: 1'b1, we: 1'b0, addr: 6'h3F, wdata: 8'h00, exp_rdata: 8'h99};
        exp_order = '{0, 0, 0, 1, 0, 0, 0, 1};

        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        pre_en = 0; pre_addr = 0; pre_data = 0;
        step();
        step();
        for (int i = 0; i < 64; i++) preload(6'(i), 8'((i * 37 + 11) & 8'hFF));
        preload(6'h3F, 8'h5C);
        chk_all_zero("reset_state");
        chk("reset_stats", {cnt_cpu, cnt_aux}, 32'd0);
        chk("reset_conflict", cnt_conflict, 32'd0);
        reset = 1'b0;

        // Both requesters held continuously: starvation forces every fourth grant to aux.
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 6'h01; addr1 = 6'h02;
        ng = 0;
        cyc = 0;
        while (ng < 8 && cyc < 100) begin
            step();
            cyc++;
            if (gnt0 && gnt1) chk("both_gnt", 32'd1, 32'd0);
            if (gnt0 || gnt1) begin
                order[ng] = gnt1 ? 1 : 0;
                ng++;
            end
        end
        req0 = 0; req1 = 0;
        chk("contention_grants", ng, 8);
        for (int i = 0; i < 8; i++) chk("grant_order", (i < ng) ? order[i] : -1, exp_order[i]);
        step(); step(); step();
`ifdef DMEM_ARB_STATS_EN
        chk("cnt_cpu", cnt_cpu, 16'd6);
        chk("cnt_aux", cnt_aux, 16'd2);
        chk("cnt_conflict", cnt_conflict, 16'd8);
`else
        chk("cnt_cpu", cnt_cpu, 16'd0);
        chk("cnt_aux", cnt_aux, 16'd0);
        chk("cnt_conflict", cnt_conflict, 16'd0);
`endif

        // Isolated single-port transactions from the table.
        for (int i = 0; i < 8; i++) do_txn(vecs[i].port, vecs[i].we, vecs[i].addr,
                                           vecs[i].wdata, vecs[i].exp_rdata);

        // Aux pulse during WAIT_RD is never sampled.
        req0 = 1; we0 = 0; addr0 = 6'h05;
        step();
        req0 = 0;
        step();
        req1 = 1; we1 = 1; addr1 = 6'h20; wdata1 = 8'hEE;
        step();
        chk("pulse_rvalid0", rvalid0, 1'b1);
        req1 = 0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (gnt0 || gnt1 || mem_read || mem_write) bad++;
        end
        chk("pulse_ignored", bad, 0);

        // Reset while a read sits in WAIT_RD drops the read.
        req0 = 1; we0 = 0; addr0 = 6'h05;
        step();
        req0 = 0;
        step();
        reset = 1;
        step();
        chk_all_zero("reset_wait_rd");
        reset = 0;
        step();
        chk("no_rvalid_after_reset", {rvalid0, rvalid1}, 32'd0);

        // Reset while a write is strobed in ISSUE still commits the write.
        req0 = 1; we0 = 1; addr0 = 6'h02; wdata0 = 8'h11;
        step();
        chk("issue_write_strobe", mem_write, 1'b1);
        req0 = 0;
        reset = 1;
        step();
        reset = 0;
        chk_all_zero("reset_issue");
        shadow[2] = 8'h11;
        do_txn(1'b0, 1'b0, 6'h02, 8'h00, 8'h11);

        // Randomized traffic against a transaction-level model.
        active[0] = 0; active[1] = 0;
        edge_idx = 0; free_edge = 0; losses = 0; rv_edge = -10; rv_port = 0; rv_data = 0;
        for (int n = 0; n < 3000; n++) begin
            s_req0 = req0; s_req1 = req1; s_we0 = we0; s_we1 = we1;
            s_addr0 = addr0; s_addr1 = addr1; s_wd0 = wdata0; s_wd1 = wdata1;
            step();
            edge_idx++;
            exp_flags = 4'b0000;
            if (edge_idx >= free_edge) begin
                if (!s_req1) losses = 0;
                if (s_req0 || s_req1) begin
                    win = s_req1 && (!s_req0 || losses >= c_STARVE_LIMIT);
                    if (win) losses = 0;
                    else if (s_req1) losses = (losses < 15) ? losses + 1 : 15;
                    exp_flags[3] = !win;
                    exp_flags[2] = win;
                    wwe   = win ? s_we1 : s_we0;
                    waddr = win ? s_addr1 : s_addr0;
                    if (wwe) begin
                        shadow[waddr] = win ? s_wd1 : s_wd0;
                        free_edge = edge_idx + 2;
                    end else begin
                        rv_edge   = edge_idx + 2;
                        rv_port   = win;
                        rv_data   = shadow[waddr];
                        free_edge = edge_idx + 3;
                    end
                end
            end
            if (edge_idx == rv_edge) begin
                exp_flags[1] = !rv_port;
                exp_flags[0] = rv_port;
            end
            chk("rand_flags", {gnt0, gnt1, rvalid0, rvalid1}, exp_flags);
            if (edge_idx == rv_edge) chk("rand_rdata", rv_port ? rdata1 : rdata0, rv_data);
            if (mem_read && mem_write) chk("rand_strobe_excl", 32'd1, 32'd0);
            if (gnt0) active[0] = 0;
            if (gnt1) active[1] = 0;
            for (int p = 0; p < 2; p++) begin
                if (active[p] && $urandom_range(15) == 0) active[p] = 0;
                if (!active[p] && $urandom_range(1) == 1) begin
                    active[p] = 1;
                    if (p == 0) begin
                        we0 = 1'($urandom_range(1)); addr0 = 6'($urandom_range(63));
                        wdata0 = 8'($urandom_range(255));
                    end else begin
                        we1 = 1'($urandom_range(1)); addr1 = 6'($urandom_range(63));
                        wdata1 = 8'($urandom_range(255));
                    end
                end
            end
            req0 = active[0];
            req1 = active[1];
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
